// File: rtl/twofour_decoder_if.sv
// Code stream interface for twofour_decoder: valid/ready code input
// plus the decoded one-hot output and FIFO status.
interface twofour_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic            in_valid;
    logic [1:0]      in_code;
    logic            in_ready;
    logic            out_valid;
    logic [3:0]      out_onehot;
    logic [CNTW-1:0] fifo_count;
    logic            drop_err;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  out_valid,
        input  out_onehot,
        input  fifo_count,
        input  drop_err
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output out_valid,
        output out_onehot,
        output fifo_count,
        output drop_err
    );
endinterface

// File: rtl/twofour_decoder.sv
// Sequential 2-to-4 decoder: FIFO-buffered codes become stretched one-hot pulses.
// Define TWOFOUR_DECODER_GAP_EN to insert one all-zero cycle after every pulse.
module twofour_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    twofour_decoder_if.slave  bus
);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef TWOFOUR_DECODER_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        HOLD
    } state_t;
`endif

    logic [1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            drop_q;
    logic            push;
    logic            pop;
    logic            have;
    logic [1:0]      head;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [3:0]      onehot_q;
    logic [3:0]      onehot_d;

    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (code)
            2'd0: oh = 4'b0001;
            2'd1: oh = 4'b0010;
            2'd2: oh = 4'b0100;
            2'd3: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // in_ready looks only at the registered count, so a full FIFO
    // refuses a push even when a pop happens on the same edge.
    assign bus.in_ready   = (count < CNTW'(FIFO_DEPTH));
    assign bus.fifo_count = count;
    assign bus.drop_err   = drop_q;

    assign push = bus.in_valid & bus.in_ready;
    assign have = (count != '0);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.in_valid && !bus.in_ready) begin
                drop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (have) begin
                    pop      = 1'b1;
                    onehot_d = decode(head);
                    cnt_d    = CW'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef TWOFOUR_DECODER_GAP_EN
                    onehot_d = 4'b0000;
                    state_d  = GAP;
`else
                    if (have) begin
                        pop      = 1'b1;
                        onehot_d = decode(head);
                        cnt_d    = CW'(HOLD_CYCLES - 1);
                    end else begin
                        onehot_d = 4'b0000;
                        state_d  = IDLE;
                    end
`endif
                end
            end
`ifdef TWOFOUR_DECODER_GAP_EN
            GAP: begin
                if (have) begin
                    pop      = 1'b1;
                    onehot_d = decode(head);
                    cnt_d    = CW'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                onehot_d = 4'b0000;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.out_valid  = (state_q == HOLD);
        bus.out_onehot = (state_q == HOLD) ? onehot_q : 4'b0000;
    end
endmodule

// File: doc/twofour_decoder.md
Name: twofour_decoder

Overview:
- Sequential 2-to-4 decoder; the inverse of the team's 4-to-2 encoder.
- Accepts a stream of 2-bit codes through a valid/ready handshake and buffers them in a small FIFO.
- Emits each code as a one-hot 4-bit pulse held for a fixed number of cycles.
- Sits between code producers (encoder or stimulus logic) and LED/strobe consumers that need stretched one-hot pulses.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output is held (legal range 1..255).
- FIFO_DEPTH, 4, code buffer entries (power of 2, at least 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  producer has a code
- in_code  input  2  code to decode
- in_ready  output  1  FIFO can accept; equals (fifo_count < FIFO_DEPTH)
- out_valid  output  1  out_onehot carries a decoded code
- out_onehot  output  4  one-hot of the current code (1 << code); 4'b0000 when out_valid=0
- fifo_count  output  $clog2(FIFO_DEPTH+1)  codes currently buffered
- drop_err  output  1  sticky: in_valid was high while in_ready was low

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Everything updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - FIFO flushed, fifo_count=0, in_ready=1.
  - out_valid=0, out_onehot=0, drop_err=0, FSM=IDLE, hold counter=0.
  - Reset mid-operation aborts the current pulse and discards buffered codes.
- Push: in_valid & in_ready at an edge writes in_code at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Drop: in_valid & !in_ready at an edge discards the code and sets drop_err=1. drop_err clears only on rst.
- Pop occurs only on FSM transitions into HOLD. Simultaneous push and pop in the same edge is legal: fifo_count is unchanged and both pointers advance.
- in_ready is combinational from fifo_count only. A full FIFO gets no push even if a pop happens in the same cycle.
- FSM states:
  - IDLE: out_valid=0. If fifo_count>0: pop, load out_onehot=1<<head, counter=HOLD_CYCLES-1, go to HOLD.
  - HOLD: out_valid=1, out_onehot stable. If counter>0, decrement. If counter==0:
    - with gap (see Optional Feature): go to GAP;
    - else if fifo_count>0: pop and reload HOLD back-to-back;
    - else go to IDLE.
  - GAP: out_valid=0, out_onehot=0 for exactly one cycle. Then, if fifo_count>0, pop into HOLD; else go to IDLE.
- A code popped in a cycle is the one visible in out_onehot after that edge.
- Latency: with the FIFO empty and the FSM in IDLE, a code accepted at edge t is visible in out_onehot after edge t+1. It is a registered output, so the first valid cycle is t+1..t+2.
- Each pulse asserts out_valid for exactly HOLD_CYCLES consecutive cycles.
- out_onehot is always either 0 or exactly one bit set. Codes 0,1,2,3 map to 0001, 0010, 0100, 1000.
- HOLD_CYCLES=1: single-cycle pulses. Back-to-back output allows a new code every cycle.
- The hold counter is wide enough for HOLD_CYCLES-1. There is no counter wrap.

Optional Feature:
- Macro: TWOFOUR_DECODER_GAP_EN.
- Defined: the GAP state exists, and every pulse is followed by one all-zero cycle. Repeated identical codes therefore appear as distinct pulses. Sustained throughput is one code per HOLD_CYCLES+1 cycles.
- Undefined: the GAP state is not compiled. HOLD reloads directly from the FIFO, with no zero cycle between pulses. Sustained throughput is one code per HOLD_CYCLES cycles.

Test Plan:
- Reset then single push of code 2 (HOLD_CYCLES=4) -> out_onehot=0100 and out_valid=1 for exactly 4 cycles starting one edge after accept, then 0000; fifo_count returns to 0.
- Push codes 0,1,2,3 on consecutive cycles, no gap macro -> out_onehot sequence 0001,0010,0100,1000, each 4 cycles, contiguous (16 cycles total); in_ready stays 1.
- Same stimulus with TWOFOUR_DECODER_GAP_EN -> each pulse is followed by one 0000 cycle (20 cycles total). Two consecutive code-3 pushes give two separated 1000 pulses.
- Push 6 codes back-to-back with FIFO_DEPTH=4 -> fifo_count hits 4, in_ready=0, and the over-depth codes are dropped with drop_err=1 (sticky). Only accepted codes appear at the output, in order.
- Assert rst for one edge during the second cycle of a pulse with 3 codes buffered -> next cycle out_valid=0, out_onehot=0, fifo_count=0, drop_err=0, in_ready=1. No buffered code is emitted afterward.
- HOLD_CYCLES=1, no gap: push codes 1,1,1 on consecutive cycles -> out_onehot=0010 for exactly 3 consecutive cycles, then 0000.
